// File: rtl/gat_feat_streamer.sv
// Streams NEW_FEATURE_DEPTH words out of a fixed-latency feature BRAM onto an AXI-Stream master,
// one run per gat_ready rising edge, with a credit-limited skid FIFO absorbing read latency.
module gat_feat_streamer #(
  parameter int unsigned NEW_FEATURE_WIDTH  = 32,
  parameter int unsigned NEW_FEATURE_DEPTH  = 43328,
  parameter int unsigned NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int unsigned RD_LATENCY         = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned FifoDepth = RD_LATENCY + 2;
  localparam int unsigned PtrW      = $clog2(FifoDepth);
  localparam int unsigned CntW      = $clog2(FifoDepth + 1);
  localparam logic [NEW_FEATURE_ADDR_W-1:0] LastIdx = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);
  localparam logic [PtrW-1:0]               LastPtr = PtrW'(FifoDepth - 1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e                        state_q, state_d;
  logic                          gat_prev_q;
  logic [NEW_FEATURE_ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [NEW_FEATURE_ADDR_W-1:0] out_idx_q, out_idx_d;
  logic [RD_LATENCY-1:0]         pipe_q;
  logic [NEW_FEATURE_WIDTH-1:0]  fifo_q [FifoDepth];
  logic [PtrW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]               count_q;
  logic [CntW-1:0]               inflight;
  logic                          start, rd_issue, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Credits cover every read already launched, so a captured word always has a free slot.
  assign inflight = CntW'($countones(pipe_q));
  assign rd_issue = (state_q == StRead) &&
                    ((int'(inflight) + int'(count_q)) < int'(FifoDepth));
  assign push     = pipe_q[RD_LATENCY-1];
  assign start    = gat_ready && !gat_prev_q;

  assign m_axis_tvalid   = (count_q != '0);
  assign m_axis_tdata    = m_axis_tvalid ? fifo_q[rd_ptr_q] : '0;
  assign m_axis_tlast    = m_axis_tvalid && (out_idx_q == LastIdx);
  assign pop             = m_axis_tvalid && m_axis_tready;
  assign feat_bram_addrb = {word_idx_q, 2'b00};
  assign busy            = (state_q == StRead) || (state_q == StDrain);
  assign done            = (state_q == StDone);

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    out_idx_d  = out_idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRead;
          word_idx_d = '0;
          out_idx_d  = '0;
        end
      end
      StRead: begin
        if (rd_issue) begin
          // Parking the index at 0 keeps the address at 0 once the run is over.
          if (word_idx_q == LastIdx) begin
            word_idx_d = '0;
            state_d    = StDrain;
          end else begin
            word_idx_d = word_idx_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (pop && m_axis_tlast) state_d = StDone;
      end
      StDone: state_d = StIdle;
    endcase
    if (pop) out_idx_d = m_axis_tlast ? '0 : out_idx_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gat_prev_q <= 1'b1;
      word_idx_q <= '0;
      out_idx_q  <= '0;
      pipe_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      gat_prev_q <= gat_ready;
      word_idx_q <= word_idx_d;
      out_idx_q  <= out_idx_d;
      pipe_q     <= RD_LATENCY'({pipe_q, rd_issue});
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= feat_bram_dout;
  end

endmodule
